seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the team's combinational N-bit ALU. Registers every result, adds carry/overflow/error flags, shifts, and a multi-cycle shift-add multiply. Sits between an operand-issue stage and a result consumer. Both sides use valid/ready handshakes, so either side may stall.

## Interface
Parameters:
- N, 32, operand/result width; power of two, ≥ 4
- SHW, $clog2(N), shift-amount width (derived; not overridden)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  block can accept an operation
- inA  input  N  operand A (unsigned unless stated)
- inB  input  N  operand B
- op  input  4  operation code
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer accepts the result
- out  output  N  result
- zero  output  1  out == 0
- carry  output  1  add: carry-out; sub: borrow (inA < inB unsigned); else 0
- overflow  output  1  add/sub signed overflow; else 0
- err  output  1  op was not a legal code

## Operation
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (unsigned, out = 1 or 0)
  - 1100 NOR
  - 1101 pack: out = {0…, inA[0], inB[0]}
  - 0011 SLL: inA << inB[SHW-1:0]
  - 0100 SRL: inA >> inB[SHW-1:0], logical
  - 1000 MUL: low N bits of inA*inB
- Any other code: out = 0, err = 1, all other flags 0, zero = 1.
- Accept happens on the edge where in_valid && in_ready. The operands and op are captured on that edge.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0.
    - Accept of a non-MUL op: compute the result, register out and flags, go to DONE.
    - Accept of MUL: load the multiplicand and multiplier, clear the accumulator, set bit counter = 0, go to MUL.
    - No accept: stay in IDLE.
  - MUL: in_ready = 0, out_valid = 0.
    - Each cycle: if the multiplier LSB is 1, acc += multiplicand (mod 2^N). Then shift the multiplicand left 1 and the multiplier right 1, and counter++.
    - When counter reaches N-1 (after N iterations), register out = acc and flags, then go to DONE.
  - DONE: in_ready = 0, out_valid = 1.
    - out and flags are held stable.
    - On out_ready = 1, go to IDLE. There is no accept in the same cycle.
- Arithmetic is width N; carry is bit N of the N+1-bit sum/difference.
- overflow for ADD: sign(A) == sign(B) and sign(out) != sign(A). For SUB: sign(A) != sign(B) and sign(out) != sign(A).
- Input signals are don't-care while in_ready = 0. Operands need not be held after the accept edge.

## Timing
- Reset values (rst high at an edge):
  - state = IDLE
  - out = 0, zero = 1
  - carry, overflow, err, out_valid = 0
  - in_ready = 1 in the first cycle after reset
  - multiply counter and datapath registers cleared
- rst takes priority over every other event, including an accept or a result handshake in the same cycle.
- Reset mid-MUL or in DONE: the in-flight operation is discarded with no output.
- Non-MUL latency: out_valid is high in the cycle after the accept edge (1 cycle).
- MUL latency: out_valid rises N+1 cycles after the accept edge. Example: N = 8 gives 9 cycles.
- Throughput:
  - Non-MUL, with out_ready held high: one op per 2 cycles (accept, DONE).
  - MUL: one op per N+2 cycles.
- Backpressure: while out_valid && !out_ready, out and all flags are held unchanged indefinitely.
- in_ready and out_valid are mutually exclusive and never both high.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- Reset and handshake:
  - Stimulus: hold rst 2 cycles, then release.
  - Required: in_ready = 1, out_valid = 0, out = 0, zero = 1.
  - Stimulus: N = 8, ADD FF + 01, out_ready = 1.
  - Required: the next cycle has out = 00, zero = 1, carry = 1, overflow = 0, out_valid = 1. in_ready returns to 1 one cycle later.
- Signed/unsigned flags, N = 8:
  - SUB 80 - 01 gives 7F, overflow = 1, carry = 0.
  - SUB 01 - 02 gives FF, carry = 1, overflow = 0.
  - SLT 03 < F0 gives 01.
- Multiply, N = 8:
  - MUL 0D * 0B gives 8F, with out_valid 9 cycles after accept and in_ready = 0 throughout.
  - MUL FF * FF gives 01 (truncated).
  - MUL 00 * 5A gives 00 with zero = 1.
- Shifts and pack, N = 8:
  - SLL 81 by inB = 09 uses shift 1 and gives 02.
  - SRL 80 by 07 gives 01.
  - op 1101 with A = 01, B = 00 gives 02.
- Backpressure and illegal op:
  - Stimulus: hold out_ready = 0 for 5 cycles after an OR A5 | 0F.
  - Required: out = AF is stable for all 5 cycles, and in_valid pulses are ignored.
  - Stimulus: op = 1111.
  - Required: out = 0, err = 1, zero = 1.
- Reset mid-operation:
  - Stimulus: assert rst in MUL cycle 4, then release.
  - Required: no out_valid pulse and full reset values.
  - Follow-up: a new ADD 02 + 03 gives 05 with normal latency.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked N-bit ALU with registered results and flags, shifts,
// and a multi-cycle shift-add multiply (one multiplier bit per clock).
module seq_alu #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         zero,
    output logic         carry,
    output logic         overflow,
    output logic         err
);

    localparam int unsigned SHW = $clog2(N);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_PACK = 4'b1101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_next;
    logic           accept;
    logic           mul_last;

    logic [N-1:0]   mcand;
    logic [N-1:0]   mplr;
    logic [N-1:0]   acc;
    logic [N-1:0]   acc_next;
    logic [SHW-1:0] cnt;

    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [N-1:0]   alu_res;
    logic           alu_carry;
    logic           alu_ovf;
    logic           alu_err;

    assign accept   = in_valid && in_ready;
    assign mul_last = (cnt == SHW'(N - 1));

    // Next-state decode for the IDLE / MUL / DONE controller
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (op == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle operations and their flags, evaluated on the live operands
    always_comb begin
        sum       = {1'b0, inA} + {1'b0, inB};
        diff      = {1'b0, inA} - {1'b0, inB};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_AND:  alu_res = inA & inB;
            OP_OR:   alu_res = inA | inB;
            OP_NOR:  alu_res = ~(inA | inB);
            OP_ADD: begin
                alu_res   = sum[N-1:0];
                alu_carry = sum[N];
                alu_ovf   = (inA[N-1] == inB[N-1]) && (sum[N-1] != inA[N-1]);
            end
            OP_SUB: begin
                alu_res   = diff[N-1:0];
                alu_carry = diff[N];
                alu_ovf   = (inA[N-1] != inB[N-1]) && (diff[N-1] != inA[N-1]);
            end
            OP_SLT:  alu_res = {{(N-1){1'b0}}, diff[N]};
            OP_PACK: alu_res = {{(N-2){1'b0}}, inA[0], inB[0]};
            OP_SLL:  alu_res = inA << inB[SHW-1:0];
            OP_SRL:  alu_res = inA >> inB[SHW-1:0];
            default: alu_err = 1'b1;
        endcase
    end

    // One shift-add step: add the multiplicand when the multiplier LSB is set
    always_comb begin
        acc_next = acc + (mplr[0] ? mcand : '0);
    end

    // State, handshake outputs, multiply datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            mcand     <= '0;
            mplr      <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == S_IDLE);
            out_valid <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            mcand <= inA;
                            mplr  <= inB;
                            acc   <= '0;
                            cnt   <= '0;
                        end else begin
                            out      <= alu_res;
                            zero     <= (alu_res == '0);
                            carry    <= alu_carry;
                            overflow <= alu_ovf;
                            err      <= alu_err;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + SHW'(1);
                    if (mul_last) begin
                        out      <= acc_next;
                        zero     <= (acc_next == '0);
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at N = 8: vector table plus backpressure and
// reset-during-multiply sequences.
module tb_seq_alu;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         err;

    int n_checks;
    int n_fail;

    typedef struct {
        string     name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;   // {zero, carry, overflow, err}
        int        lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    seq_alu #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inA       (inA),
        .inB       (inB),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        check({name, " in_ready"},  32'(in_ready),  32'd1);
        check({name, " out_valid"}, 32'(out_valid), 32'd0);
        check({name, " out/zero"},  {23'd0, out, zero}, {23'd0, 8'h00, 1'b1});
        check({name, " c/o/e"},     {29'd0, carry, overflow, err}, 32'd0);
    endtask

    // Issue one op with out_ready high; report result, flags and latency.
    task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic [3:0] f, output int lat,
                          output logic rdy_seen);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("wait in_ready", 32'(in_ready), 32'd1);
        op = o; inA = a; inB = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; inA = 8'hxx; inB = 8'hxx; op = 4'hx;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 50) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        r = out;
        f = {zero, carry, overflow, err};
        tick();
        check("in_ready after DONE", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    endtask

    initial begin
        logic [7:0] r;
        logic [3:0] f;
        int         lat;
        logic       rdy_seen;
        logic       vseen;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{"ADD FF+01",  4'b0010, 8'hFF, 8'h01, 8'h00, 4'b1100, 1};
        vecs[1]  = '{"SUB 80-01",  4'b0110, 8'h80, 8'h01, 8'h7F, 4'b0010, 1};
        vecs[2]  = '{"SUB 01-02",  4'b0110, 8'h01, 8'h02, 8'hFF, 4'b0100, 1};
        vecs[3]  = '{"SLT 03<F0",  4'b0111, 8'h03, 8'hF0, 8'h01, 4'b0000, 1};
        vecs[4]  = '{"SLT F0<03",  4'b0111, 8'hF0, 8'h03, 8'h00, 4'b1000, 1};
        vecs[5]  = '{"MUL 0D*0B",  4'b1000, 8'h0D, 8'h0B, 8'h8F, 4'b0000, 9};
        vecs[6]  = '{"MUL FF*FF",  4'b1000, 8'hFF, 8'hFF, 8'h01, 4'b0000, 9};
        vecs[7]  = '{"MUL 00*5A",  4'b1000, 8'h00, 8'h5A, 8'h00, 4'b1000, 9};
        vecs[8]  = '{"SLL 81<<09", 4'b0011, 8'h81, 8'h09, 8'h02, 4'b0000, 1};
        vecs[9]  = '{"SRL 80>>07", 4'b0100, 8'h80, 8'h07, 8'h01, 4'b0000, 1};
        vecs[10] = '{"PACK 01,00", 4'b1101, 8'h01, 8'h00, 8'h02, 4'b0000, 1};
        vecs[11] = '{"ILLEGAL F",  4'b1111, 8'h12, 8'h34, 8'h00, 4'b1001, 1};
        vecs[12] = '{"AND F0&3C",  4'b0000, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1};
        vecs[13] = '{"NOR 0F,30",  4'b1100, 8'h0F, 8'h30, 8'hC0, 4'b0000, 1};
        vecs[14] = '{"ADD 7F+01",  4'b0010, 8'h7F, 8'h01, 8'h80, 4'b0010, 1};
        vecs[15] = '{"ILLEGAL 5",  4'b0101, 8'hFF, 8'hFF, 8'h00, 4'b1001, 1};
        vecs[16] = '{"MUL 07*03",  4'b1000, 8'h07, 8'h03, 8'h15, 4'b0000, 9};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        inA = '0; inB = '0; op = '0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");
        tick();
        check_reset_state("idle after reset");

        // Table of single operations
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, rdy_seen);
            check({vecs[i].name, " out"},   32'(r),   32'(vecs[i].res));
            check({vecs[i].name, " flags"}, 32'(f),   32'(vecs[i].flg));
            check({vecs[i].name, " lat"},   32'(lat), 32'(vecs[i].lat));
            if (vecs[i].lat > 1) check({vecs[i].name, " in_ready low"}, 32'(rdy_seen), 32'd0);
        end

        // Backpressure: result held while the consumer stalls; inputs ignored
        out_ready = 1'b0;
        op = 4'b0001; inA = 8'hA5; inB = 8'h0F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            op = 4'b0010; inA = 8'h11 * 8'(k + 1); inB = 8'h01; in_valid = 1'b1;
            tick();
            check("bp hold out", {22'd0, out, out_valid, in_ready}, {22'd0, 8'hAF, 1'b1, 1'b0});
            check("bp hold flags", 32'({zero, carry, overflow, err}), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        tick();
        check("bp no stray result", {22'd0, out, out_valid, in_ready}, {22'd0, 8'hAF, 1'b0, 1'b1});

        // Reset during multiply cycle 4 discards the operation
        op = 4'b1000; inA = 8'h0D; inB = 8'h0B; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("mid-MUL reset");
        vseen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid) vseen = 1'b1;
            tick();
        end
        check("no out_valid after reset", 32'(vseen), 32'd0);
        check_reset_state("after reset idle");

        run_op(4'b0010, 8'h02, 8'h03, r, f, lat, rdy_seen);
        check("post-reset ADD out",   32'(r),   32'h05);
        check("post-reset ADD flags", 32'(f),   32'd0);
        check("post-reset ADD lat",   32'(lat), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // Handshake outputs must never both be high
    always @(negedge clk) begin
        if (in_ready && out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready/valid exclusive: got both 1, expected at most one");
        end
    end

endmodule
